twiddle_gen: RTL and testbench

- Generates the twiddle-factor stream W_N^e = cos(2πe/N) − j·sin(2πe/N) for one radix-2 DIT FFT stage.
- Feeds the b_r/b_i operands of the stage complex multiplier, one twiddle per accepted butterfly beat.
- Walks the butterfly index internally, addresses a quarter-wave cosine ROM and applies quadrant symmetry.
- Pipelined and valid-tagged, at a fixed latency of 3 cycles.

---
 rtl/twiddle_pkg.sv | 47 ++++
 rtl/twiddle_if.sv | 26 ++
 rtl/twiddle_rom.sv | 32 +++
 rtl/twiddle_gen.sv | 155 +++++++++++++++
 tb/tb_twiddle_gen.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/twiddle_pkg.sv
// Shared definitions for the FFT twiddle-factor generator.
//   LATENCY     : cycles from an accepted beat to its output
//   state_e     : frame controller states
//   clamp_stage : limits a requested stage number to the last valid stage
//   rom_entry   : quarter-wave cosine table entry, evaluated at elaboration
package twiddle_pkg;

  localparam int unsigned LATENCY = 3;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  function automatic int unsigned clamp_stage(int unsigned stage, int unsigned log2n);
    return (stage >= log2n) ? (log2n - 1) : stage;
  endfunction

  // C[i] = round(cos(2*pi*i/N) * 2^(width-1)), saturated to 2^(width-1)-1, C[N/4] = 0.
  // Cosine is evaluated with a Taylor series so only plain real arithmetic is needed.
  // Valid for width <= 31.
  function automatic int rom_entry(int i, int log2n, int width);
    real x;
    real term;
    real sum;
    real scale;
    real r;
    int  max_v;
    max_v = (1 << (width - 1)) - 1;
    if (i == (1 << (log2n - 2))) return 0;
    x    = 2.0 * 3.14159265358979323846 * real'(i) / real'(1 << log2n);
    term = 1.0;
    sum  = 1.0;
    for (int k = 1; k <= 16; k++) begin
      term = -term * x * x / real'((2 * k - 1) * (2 * k));
      sum  = sum + term;
    end
    scale = 1.0;
    for (int k = 0; k < width - 1; k++) scale = scale * 2.0;
    r = sum * scale;
    // Angles are within [0, pi/2), so only rounding noise can go negative.
    if (r < 0.0) return 0;
    if (r + 0.5 >= real'(max_v)) return max_v;
    return $rtoi(r + 0.5);
  endfunction

endpackage

// File: rtl/twiddle_if.sv
// Handshake bundle between a butterfly-stage controller and the twiddle generator.
//   master : drives start/stage/in_valid, receives twiddles and status
//   slave  : the generator side
interface twiddle_if #(
  parameter int unsigned LOG2N      = 10,
  parameter int unsigned TWID_WIDTH = 16
);
  logic                         start;
  logic [LOG2N-1:0]             stage;
  logic                         in_valid;
  logic signed [TWID_WIDTH-1:0] b_r;
  logic signed [TWID_WIDTH-1:0] b_i;
  logic                         out_valid;
  logic                         busy;
  logic                         frame_done;

  modport master (
    output start, stage, in_valid,
    input  b_r, b_i, out_valid, busy, frame_done
  );

  modport slave (
    input  start, stage, in_valid,
    output b_r, b_i, out_valid, busy, frame_done
  );
endinterface

// File: rtl/twiddle_rom.sv
// Dual-read, synchronous-read quarter-wave cosine ROM with N/4+1 entries.
//   clk            : clock
//   addr_a, addr_b : read addresses, 0..N/4
//   data_a, data_b : registered read data, one cycle after the address
module twiddle_rom
  import twiddle_pkg::*;
#(
  parameter int unsigned LOG2N      = 10,
  parameter int unsigned TWID_WIDTH = 16
) (
  input  logic                  clk,
  input  logic [LOG2N-2:0]      addr_a,
  input  logic [LOG2N-2:0]      addr_b,
  output logic [TWID_WIDTH-1:0] data_a,
  output logic [TWID_WIDTH-1:0] data_b
);

  localparam int unsigned Depth = (1 << (LOG2N - 2)) + 1;

  logic [TWID_WIDTH-1:0] rom [Depth];

  for (genvar i = 0; i < Depth; i++) begin : g_rom
    localparam int Val = rom_entry(i, LOG2N, TWID_WIDTH);
    assign rom[i] = TWID_WIDTH'(Val);
  end

  always_ff @(posedge clk) begin
    data_a <= rom[addr_a];
    data_b <= rom[addr_b];
  end

endmodule

// File: rtl/twiddle_gen.sv
// Twiddle-factor stream W_N^e = cos(2*pi*e/N) - j*sin(2*pi*e/N) for one radix-2 DIT stage.
//   clk : clock
//   rst : asynchronous active-high reset
//   bus : twiddle_if slave
//         start/stage latch a new frame; in_valid is one butterfly beat
//         b_r/b_i/out_valid arrive 3 cycles after each accepted beat
//         busy while a frame runs; frame_done marks the output of the last twiddle
module twiddle_gen
  import twiddle_pkg::*;
#(
  parameter int unsigned LOG2N      = 10,
  parameter int unsigned TWID_WIDTH = 16
) (
  input logic      clk,
  input logic      rst,
  twiddle_if.slave bus
);

  localparam int unsigned JW = LOG2N - 1;  // butterfly index, exponent and ROM address width
  localparam logic [JW-1:0] Quarter = JW'(1 << (LOG2N - 2));
  localparam logic [JW-1:0] JLast   = '1;  // N/2-1

  state_e           state_q, state_d;
  logic [JW-1:0]    j_q, j_d;
  logic [LOG2N-1:0] stage_q, stage_d;

  logic [LOG2N-1:0] stage_eff;
  logic [JW-1:0]    j_eff;
  logic [JW-1:0]    mask;
  logic [JW-1:0]    e;
  logic [JW-1:0]    e_low;
  logic [JW-1:0]    addr_re, addr_im;
  logic             accept;
  logic             last;
  logic             quad;

  // Pipeline registers: P1 addresses, P2 ROM data, P3 outputs.
  logic                         v1_q, quad1_q, last1_q;
  logic [JW-1:0]                addr_re_q, addr_im_q;
  logic                         v2_q, quad2_q, last2_q;
  logic [TWID_WIDTH-1:0]        rom_re, rom_im;
  logic signed [TWID_WIDTH-1:0] b_r_q, b_i_q;
  logic                         out_valid_q, frame_done_q;

  always_comb begin
    // A start beat belongs to the new frame, so index/stage come from the start values.
    stage_eff = bus.start ? LOG2N'(clamp_stage(32'(bus.stage), LOG2N)) : stage_q;
    j_eff     = bus.start ? '0 : j_q;
    accept    = bus.in_valid & (bus.start | (state_q == StRun));
    last      = accept & (j_eff == JLast);

    state_d = state_q;
    j_d     = j_q;
    stage_d = stage_q;
    if (bus.start) begin
      state_d = StRun;
      j_d     = '0;
      stage_d = stage_eff;
    end
    if (accept) begin
      j_d = j_eff + 1'b1;
      if (last) state_d = StIdle;
    end

    // e = (j mod 2^s) << (LOG2N-1-s)
    mask  = ~({JW{1'b1}} << stage_eff);
    e     = (j_eff & mask) << (JW - 32'(stage_eff));
    quad  = e[JW-1];
    e_low = {1'b0, e[JW-2:0]};
    if (!quad) begin
      addr_re = e;
      addr_im = Quarter - e;
    end else begin
      addr_re = Quarter - e_low;
      addr_im = e_low;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      j_q     <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      stage_q <= stage_d;
    end
  end

  // P1: exponent decode into quadrant flag and two ROM addresses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q      <= 1'b0;
      quad1_q   <= 1'b0;
      last1_q   <= 1'b0;
      addr_re_q <= '0;
      addr_im_q <= '0;
    end else begin
      v1_q      <= accept;
      quad1_q   <= quad;
      last1_q   <= last;
      addr_re_q <= addr_re;
      addr_im_q <= addr_im;
    end
  end

  // P2: ROM read; valid bits in flight are killed by a start.
  twiddle_rom #(
    .LOG2N     (LOG2N),
    .TWID_WIDTH(TWID_WIDTH)
  ) u_rom (
    .clk   (clk),
    .addr_a(addr_re_q),
    .addr_b(addr_im_q),
    .data_a(rom_re),
    .data_b(rom_im)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q    <= 1'b0;
      quad2_q <= 1'b0;
      last2_q <= 1'b0;
    end else begin
      v2_q    <= v1_q & ~bus.start;
      quad2_q <= quad1_q;
      last2_q <= last1_q;
    end
  end

  // P3: quadrant sign/swap. Imaginary part is always -C[.]; real part negates in quadrant 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_r_q        <= '0;
      b_i_q        <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      out_valid_q  <= v2_q & ~bus.start;
      frame_done_q <= v2_q & last2_q & ~bus.start;
      if (v2_q && !bus.start) begin
        b_r_q <= quad2_q ? -$signed(rom_re) : $signed(rom_re);
        b_i_q <= -$signed(rom_im);
      end
    end
  end

  assign bus.b_r        = b_r_q;
  assign bus.b_i        = b_i_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = (state_q == StRun);

endmodule

// File: tb/tb_twiddle_gen.sv
module tb_twiddle_gen;
  localparam int LOG2N = 4;
  localparam int TW    = 16;
  localparam int N     = 1 << LOG2N;
  localparam real PI   = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  twiddle_if #(.LOG2N(LOG2N), .TWID_WIDTH(TW)) bus ();

  twiddle_gen #(.LOG2N(LOG2N), .TWID_WIDTH(TW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int br;
    int bi;
    bit fd;
    int stamp;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   chk_en = 0;
  bit   running = 0;
  bit   exp_busy = 0;
  int   stage_m = 0;
  int   j_m = 0;
  int   last_br = 0;
  int   last_bi = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Ideal twiddle component in Q1.15, rounded to nearest, magnitude limited to 32767.
  function automatic int quant(real x);
    real r;
    int  v;
    r = x * 32768.0;
    if (r >= 0.0) v = $rtoi(r + 0.5);
    else v = -$rtoi(-r + 0.5);
    if (v > 32767) v = 32767;
    if (v < -32767) v = -32767;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  // One clock of stimulus plus the reference model update.
  task automatic step(input bit st, input int stg, input bit iv);
    exp_t tmp[$];
    exp_t x;
    int   e;
    real  ang;
    @(posedge clk);
    #1;
    exp_busy     = running;
    bus.start    = st;
    bus.stage    = 4'(stg);
    bus.in_valid = iv;
    if (st) begin
      // Beats issued in the two previous cycles are still in flight and get dropped.
      foreach (q[k]) if (q[k].stamp < cyc - 2) tmp.push_back(q[k]);
      q       = tmp;
      stage_m = (stg >= LOG2N) ? LOG2N - 1 : stg;
      j_m     = 0;
      running = 1;
    end
    if (iv && running) begin
      e       = (j_m % (1 << stage_m)) * (1 << (LOG2N - 1 - stage_m));
      ang     = 2.0 * PI * real'(e) / real'(N);
      x.br    = quant($cos(ang));
      x.bi    = quant(-$sin(ang));
      x.fd    = (j_m == N / 2 - 1);
      x.stamp = cyc;
      q.push_back(x);
      j_m++;
      if (j_m == N / 2) running = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("rst_b_r", int'(bus.b_r), 0);
    check("rst_b_i", int'(bus.b_i), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_frame_done", int'(bus.frame_done), 0);
    q.delete();
    running  = 0;
    exp_busy = 0;
    last_br  = 0;
    last_bi  = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("busy", int'(bus.busy), int'(exp_busy));
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output at cycle %0d: got b_r=%0d b_i=%0d, expected none",
                   cyc, bus.b_r, bus.b_i);
        end else begin
          exp_t x;
          x = q.pop_front();
          check("b_r", int'(bus.b_r), x.br);
          check("b_i", int'(bus.b_i), x.bi);
          check("frame_done", int'(bus.frame_done), int'(x.fd));
          check("latency", cyc - x.stamp, 3);
          last_br = x.br;
          last_bi = x.bi;
        end
      end else begin
        check("hold_b_r", int'(bus.b_r), last_br);
        check("hold_b_i", int'(bus.b_i), last_bi);
        check("frame_done_idle", int'(bus.frame_done), 0);
      end
    end
  end

  initial begin
    bit iv;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.stage    = '0;
    bus.in_valid = 1'b0;
    #1;
    check("init_b_r", int'(bus.b_r), 0);
    check("init_out_valid", int'(bus.out_valid), 0);
    check("init_busy", int'(bus.busy), 0);
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1;

    // Stage 0: every twiddle is W^0.
    step(1, 0, 0);
    for (int k = 0; k < 8; k++) step(0, 0, 1);
    idle(6);

    // Stage 3: full sweep of the half circle.
    step(1, 3, 0);
    for (int k = 0; k < 8; k++) step(0, 0, 1);
    idle(6);

    // Stage 1 with gaps in the beat stream.
    step(1, 1, 0);
    step(0, 0, 1); step(0, 0, 0); step(0, 0, 1);
    step(0, 0, 1); step(0, 0, 0); step(0, 0, 1);
    idle(5);

    // Stage 7 clamps to 3; start carries the first beat.
    step(1, 7, 1);
    for (int k = 0; k < 7; k++) step(0, 0, 1);
    idle(6);

    // Restart mid-frame after five beats.
    step(1, 3, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 1);
    step(1, 2, 0);
    for (int k = 0; k < 8; k++) step(0, 0, 1);
    idle(6);

    // Reset mid-frame after three beats.
    step(1, 3, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 1);
    do_reset();
    idle(6);

    // Beats while idle are ignored.
    for (int k = 0; k < 5; k++) step(0, 0, 1);
    idle(4);

    // Random frames with random gaps and occasional restarts.
    for (int f = 0; f < 30; f++) begin
      step(1, int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)));
      for (int c = 0; c < 60 && running; c++) begin
        iv = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 39) == 0) step(1, int'($urandom_range(0, 7)), iv);
        else step(0, 0, iv);
      end
      idle(int'($urandom_range(0, 5)));
    end
    idle(6);

    check("queue_drained", q.size(), 0);
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout at cycle %0d: got no end, expected finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
